// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM state encoding and a
// ceiling-log2 helper used to size index and counter fields.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Number of bits needed to index n distinct values (minimum 0).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans the request vector starting one
// position after ptr (wrapping) and reports the first requester found.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      winner,
    output logic               any_req
);

    int   idx;
    logic found;

    // First set bit at or after ptr+1, modulo NUM_REQ.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[IW'(idx)]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Multiplexes NUM_REQ word streams into one FIFO write port. A granted
// requester keeps the port for up to MAX_BURST beats; at burst end the next
// owner is chosen round-robin in the same cycle so back-to-back bursts have
// no bubble. Only the very first grant out of IDLE costs one cycle.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [clog2(NUM_REQ)-1:0]     grant_id,
    output logic                          busy
);

    localparam int IW = clog2(NUM_REQ);
    localparam int BW = clog2(MAX_BURST) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
    localparam logic [IW-1:0] RST_PTR   = IW'(NUM_REQ - 1);

    state_t            state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;

    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] arb_req;
    logic [IW-1:0]      winner;
    logic               any_req;
    logic               owner_vld;
    logic               xfer;
    logic               burst_end;

    assign owner_oh  = NUM_REQ'(1) << owner_q;
    assign owner_vld = req_valid[owner_q];
    assign xfer      = (state_q == BURST) && owner_vld && !fifo_full && !rst;
    assign burst_end = !owner_vld || (xfer && (beat_cnt_q == LAST_BEAT));

    // Keep the outgoing owner out of the next grant while anyone else waits.
    always_comb begin
        arb_req = req_valid;
        if ((state_q == BURST) && owner_vld && (|(req_valid & ~owner_oh))) begin
            arb_req = req_valid & ~owner_oh;
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_arbiter (
        .req     (arb_req),
        .ptr     (rr_ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    // State register: reset abandons any burst in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= RST_PTR;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Next-state: grant from IDLE, count beats, hand over or retire at burst end.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d    = BURST;
                    owner_d    = winner;
                    rr_ptr_d   = winner;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                end
                if (burst_end) begin
                    beat_cnt_d = '0;
                    if (any_req) begin
                        owner_d  = winner;
                        rr_ptr_d = winner;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: zero-latency data pass-through from the current owner.
    always_comb begin
        req_ready = '0;
        if ((state_q == BURST) && !fifo_full && !rst) begin
            req_ready = owner_oh;
        end
        fifo_wr   = xfer;
        fifo_data = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
        grant_id  = owner_q;
        busy      = (state_q == BURST);
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed table-driven bench for fifo_wr_arbiter (4 requesters, bursts of 4).
// Inputs change on the falling edge; combinational outputs are sampled 1ns later.
module tb_fifo_wr_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int MB = 4;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              fifo_full;
    logic              fifo_wr;
    logic [DW-1:0]     fifo_data;
    logic [1:0]        grant_id;
    logic              busy;

    int tests;
    int failed;

    fifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BURST  (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_data (fifo_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic        full;
        logic [31:0] dat;
        logic        wr;
        logic [3:0]  rdy;
        logic [1:0]  gid;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] v, input logic f,
                       input logic [31:0] d, input logic w, input logic [3:0] rd,
                       input logic [1:0] g, input logic b);
        vec_t t;
        t.rst = r; t.vld = v; t.full = f; t.dat = d;
        t.wr = w; t.rdy = rd; t.gid = g; t.busy = b;
        vecs.push_back(t);
    endtask

    // Requester i presents dat with its index in bits [23:16].
    task automatic set_data(input logic [31:0] d);
        for (int i = 0; i < NR; i++) begin
            req_data[i*DW +: DW] = d | (32'(i) << 16);
        end
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        rst       = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        set_data(32'h0);

        // Two reset rows with everyone requesting, then IDLE arbitration.
        add(1, 4'b1111, 0, 32'h0, 0, 4'b0000, 0, 0);
        add(1, 4'b1111, 0, 32'h0, 0, 4'b0000, 0, 0);
        add(0, 4'b1111, 0, 32'h0, 0, 4'b0000, 0, 0);
        // All requesting: owners 0,1,2,3 for 4 beats each, then 0 again.
        for (int g = 0; g < 4; g++) begin
            for (int b = 0; b < 4; b++) begin
                add(0, 4'b1111, 0, 32'h100 + 32'(g*4 + b), 1, 4'b0001 << g, 2'(g), 1);
            end
        end
        add(0, 4'b1111, 0, 32'h120, 1, 4'b0001, 0, 1);
        // Reset pulse on beat 2 of requester 0's burst.
        add(1, 4'b1111, 0, 32'h121, 0, 4'b0000, 0, 1);
        add(0, 4'b0000, 0, 32'h0,   0, 4'b0000, 0, 0);
        // Only requester 2: one bubble, six writes with re-grant after beat 4.
        add(0, 4'b0100, 0, 32'h0, 0, 4'b0000, 0, 0);
        for (int k = 0; k < 6; k++) begin
            add(0, 4'b0100, 0, 32'hA0 + 32'(k), 1, 4'b0100, 2, 1);
        end
        add(0, 4'b0000, 0, 32'h0, 0, 4'b0100, 2, 1);
        add(0, 4'b0000, 0, 32'h0, 0, 4'b0000, 2, 0);
        // Requester 1 with a 3-cycle FIFO-full stall after beat 2.
        add(0, 4'b0010, 0, 32'h0,  0, 4'b0000, 2, 0);
        add(0, 4'b0010, 0, 32'h30, 1, 4'b0010, 1, 1);
        add(0, 4'b0010, 0, 32'h31, 1, 4'b0010, 1, 1);
        for (int k = 0; k < 3; k++) begin
            add(0, 4'b0010, 1, 32'h32, 0, 4'b0000, 1, 1);
        end
        add(0, 4'b0010, 0, 32'h33, 1, 4'b0010, 1, 1);
        add(0, 4'b0010, 0, 32'h34, 1, 4'b0010, 1, 1);
        add(0, 4'b0000, 0, 32'h0,  0, 4'b0010, 1, 1);
        add(0, 4'b0000, 0, 32'h0,  0, 4'b0000, 1, 0);
        // Requester 0 drops after one beat, requester 3 takes over with no bubble.
        add(0, 4'b0001, 0, 32'h0,  0, 4'b0000, 1, 0);
        add(0, 4'b1001, 0, 32'h40, 1, 4'b0001, 0, 1);
        add(0, 4'b1000, 0, 32'h41, 0, 4'b0001, 0, 1);
        add(0, 4'b1000, 0, 32'h42, 1, 4'b1000, 3, 1);

        // Initial reset edge so every register is defined before row 0.
        @(posedge clk);

        foreach (vecs[r]) begin
            @(negedge clk);
            rst       = vecs[r].rst;
            req_valid = vecs[r].vld;
            fifo_full = vecs[r].full;
            set_data(vecs[r].dat);
            #1;
            chk("fifo_wr",   r, 32'(fifo_wr),   32'(vecs[r].wr));
            chk("req_ready", r, 32'(req_ready), 32'(vecs[r].rdy));
            chk("grant_id",  r, 32'(grant_id),  32'(vecs[r].gid));
            chk("busy",      r, 32'(busy),      32'(vecs[r].busy));
            if (vecs[r].wr) begin
                chk("fifo_data", r, fifo_data, vecs[r].dat | (32'(vecs[r].gid) << 16));
            end
        end

        // Hand sequence: after reset, a lone request sees exactly one bubble.
        begin
            int lat;
            lat = -1;
            @(negedge clk);
            rst       = 1'b1;
            req_valid = 4'b0000;
            fifo_full = 1'b0;
            @(negedge clk);
            rst       = 1'b0;
            req_valid = 4'b0100;
            set_data(32'h55);
            for (int c = 0; c < 10; c++) begin
                #1;
                if (fifo_wr) begin
                    lat = c;
                    break;
                end
                @(negedge clk);
            end
            chk("first_write_latency", 0, 32'(lat), 32'd1);
            chk("first_write_gid",     0, 32'(grant_id), 32'd2);
            chk("first_write_data",    0, fifo_data, 32'h0002_0055);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of each requester word and of the FIFO write data.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (range 2..16).
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum consecutive beats per grant (range 1..256).
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port req_valid  in  NUM_REQ  bit i: requester i offers a word.
REQ-007 SHALL have port req_data  in  NUM_REQ*DATA_WIDTH  requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_ready  out  NUM_REQ  bit i: requester i word accepted this cycle when req_valid[i] is also high.
REQ-009 SHALL have port fifo_full  in  1  full flag of the downstream FIFO.
REQ-010 SHALL have port fifo_wr  out  1  write strobe to the FIFO.
REQ-011 SHALL have port fifo_data  out  DATA_WIDTH  write data to the FIFO.
REQ-012 SHALL have port grant_id  out  log2(NUM_REQ)  current owner index.
REQ-013 SHALL have port busy  out  1  high while in state BURST.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, BURST; registers: state, owner, rr_ptr, beat_cnt.
REQ-015 Transfer SHALL occur when state==BURST, req_valid[owner]==1, fifo_full==0 and rst==0.
REQ-016 req_ready[i] SHALL equal (state==BURST && owner==i && !fifo_full && !rst), combinational; all other bits 0.
REQ-017 fifo_wr SHALL equal the transfer condition; fifo_data SHALL equal req_data word of owner (zero-latency pass-through).
REQ-018 Arbitration SHALL be round-robin: search starts at rr_ptr+1 (mod NUM_REQ), first requester with req_valid high wins.
REQ-019 IDLE: if any req_valid high, next cycle state=BURST, owner=winner, rr_ptr=winner, beat_cnt=0; else stay IDLE (one-cycle arbitration bubble).
REQ-020 BURST with transfer: beat_cnt increments; if beat_cnt==MAX_BURST-1 the burst ends.
REQ-021 BURST with req_valid[owner]==0: the burst ends, no transfer that cycle.
REQ-022 Burst end: re-arbitrate over req_valid in the same cycle, with the current owner masked if it still has req_valid high and another requester is valid; on a winner, next cycle owner=winner, rr_ptr=winner, beat_cnt=0, stay BURST (no bubble); if no requester valid, go IDLE.
REQ-023 BURST with fifo_full==1 and req_valid[owner]==1: stall; owner and beat_cnt hold; no timeout.
REQ-024 beat_cnt SHALL be log2(MAX_BURST)+1 bits wide and never exceed MAX_BURST-1.
REQ-025 A requester lowering req_valid without a handshake SHALL cause no FIFO write.

Reset
REQ-026 While rst is high: req_ready=0, fifo_wr=0 that cycle.
REQ-027 On the clock edge with rst high: state=IDLE, owner=0, rr_ptr=NUM_REQ-1 (first search starts at 0), beat_cnt=0; hence grant_id=0, busy=0.
REQ-028 rst asserted mid-burst SHALL abandon the burst; no partial write beyond beats already strobed.

Structure
REQ-029 Package fifo_arb_pkg SHALL hold the state encoding constants (IDLE=0, BURST=1) and the log2 ceiling function.
REQ-030 Sub-module rr_arbiter SHALL be combinational: inputs request vector and pointer; outputs winner index and any_req; instantiated once.

Verification (NUM_REQ=4, MAX_BURST=4, DATA_WIDTH=32)
REQ-031 rst high 2 cycles with req_valid=1111 -> fifo_wr=0, req_ready=0000, grant_id=0, busy=0 throughout; busy rises 1 cycle after rst falls.
REQ-032 Only req 2 valid, data 0xA0..0xA5 -> 1 IDLE cycle, then 6 consecutive writes A0..A5, grant_id=2, re-grant at beat 4 without bubble.
REQ-033 req_valid=1111 continuously, no full -> grants 0,1,2,3,0 each 4 beats; fifo_wr high every cycle after the first.
REQ-034 Req 1 bursting, fifo_full high 3 cycles after beat 2 -> fifo_wr=0, req_ready=0000, grant_id=1 held, then 2 remaining beats written.
REQ-035 Req 0 drops valid after 1 beat while req 3 valid -> next cycle grant_id=3, busy stays 1, no IDLE cycle.
REQ-036 rst pulsed 1 cycle during beat 2 of req 0 -> no write that cycle; next cycle state IDLE, grant_id=0, busy=0.
